// File: rtl/context_switch_ctrl.sv
// Kernel-side context switch controller: dispatches processes into the program PC,
// times their slice and saves their PC on preemption or syscall. Optional macro: CTXSW_RUNTIME_EN.
module context_switch_ctrl #(
  parameter int PC_W  = 32,
  parameter int NPROC = 8,
  parameter int PID_W = 3,
  parameter int Q_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc_prog_at,
  input  logic             syscall,
  input  logic             run_req,
  input  logic [PID_W-1:0] run_pid,
  input  logic [Q_W-1:0]   quantum,
  input  logic             tbl_we,
  input  logic [PID_W-1:0] tbl_addr,
  input  logic [PC_W-1:0]  tbl_data,
  output logic             prog_or_kernel,
  output logic             set_pc_prog,
  output logic [PC_W-1:0]  pc_reg,
  output logic [PID_W-1:0] cur_pid,
  output logic             trap_valid,
  output logic [1:0]       trap_cause,
  input  logic [PID_W-1:0] stat_pid,
  output logic [31:0]      stat_cycles
);

  typedef enum logic [1:0] {
    KERNEL = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    SAVE   = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_QUANTUM = 2'b01;
  localparam logic [1:0] CAUSE_SYSCALL = 2'b10;

  state_t state;
  state_t next_state;

  logic [Q_W-1:0]   count;
  logic             q_en;
  logic [PC_W-1:0]  save_tbl [NPROC];

  logic             run_pid_ok;
  logic             dispatch;
  logic             trap;
  logic [1:0]       trap_cause_d;
  logic [PC_W-1:0]  tbl_rd;
  logic [PC_W-1:0]  dispatch_pc;
  logic             tbl_wr_en;
  logic [PID_W-1:0] tbl_wr_idx;
  logic [PC_W-1:0]  tbl_wr_val;

  assign run_pid_ok = 32'(run_pid) < NPROC;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= KERNEL;
    end else if (!halt) begin
      state <= next_state;
    end
  end

  // q_en remembers whether this slice was started with a nonzero quantum.
  always_comb begin
    next_state   = state;
    dispatch     = 1'b0;
    trap         = 1'b0;
    trap_cause_d = CAUSE_QUANTUM;
    case (state)
      KERNEL: begin
        if (run_req && run_pid_ok) begin
          dispatch   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = RUN;
      end
      RUN: begin
        if (syscall) begin
          trap         = 1'b1;
          trap_cause_d = CAUSE_SYSCALL;
          next_state   = SAVE;
        end else if (q_en && (count == Q_W'(1))) begin
          trap       = 1'b1;
          next_state = SAVE;
        end
      end
      SAVE: begin
        next_state = KERNEL;
      end
      default: begin
        next_state = KERNEL;
      end
    endcase
  end

  always_comb begin
    tbl_rd = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (run_pid == PID_W'(i)) begin
        tbl_rd = save_tbl[i];
      end
    end
  end

  // A same-cycle kernel write to the dispatched slot wins over the stale table entry.
  always_comb begin
    dispatch_pc = tbl_rd;
    if (tbl_we && (tbl_addr == run_pid)) begin
      dispatch_pc = tbl_data;
    end
    tbl_wr_en  = 1'b0;
    tbl_wr_idx = tbl_addr;
    tbl_wr_val = tbl_data;
    case (state)
      KERNEL: begin
        tbl_wr_en = tbl_we;
      end
      SAVE: begin
        tbl_wr_en  = 1'b1;
        tbl_wr_idx = cur_pid;
        tbl_wr_val = (trap_cause == CAUSE_SYSCALL) ? (pc_prog_at + PC_W'(1)) : pc_prog_at;
      end
      default: begin
        tbl_wr_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        save_tbl[i] <= '0;
      end
    end else if (!halt && tbl_wr_en) begin
      for (int i = 0; i < NPROC; i++) begin
        if (tbl_wr_idx == PID_W'(i)) begin
          save_tbl[i] <= tbl_wr_val;
        end
      end
    end
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      prog_or_kernel <= 1'b0;
      set_pc_prog    <= 1'b0;
      trap_valid     <= 1'b0;
      pc_reg         <= '0;
      cur_pid        <= '0;
      trap_cause     <= CAUSE_NONE;
      count          <= '0;
      q_en           <= 1'b0;
    end else if (!halt) begin
      prog_or_kernel <= (next_state == RUN);
      set_pc_prog    <= (next_state == LOAD);
      trap_valid     <= (next_state == SAVE);
      if (dispatch) begin
        cur_pid    <= run_pid;
        pc_reg     <= dispatch_pc;
        count      <= quantum;
        q_en       <= (quantum != '0);
        trap_cause <= CAUSE_NONE;
      end else if (state == RUN) begin
        if (q_en) begin
          count <= count - Q_W'(1);
        end
        if (trap) begin
          trap_cause <= trap_cause_d;
        end
      end
    end
  end

`ifdef CTXSW_RUNTIME_EN
  logic [31:0] runtime [NPROC];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        runtime[i] <= '0;
      end
    end else if (!halt && (state == RUN)) begin
      for (int i = 0; i < NPROC; i++) begin
        if (cur_pid == PID_W'(i)) begin
          runtime[i] <= runtime[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_cycles = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (stat_pid == PID_W'(i)) begin
        stat_cycles = runtime[i];
      end
    end
  end
`else
  logic unused_stat_pid;
  assign unused_stat_pid = ^stat_pid;
  assign stat_cycles     = '0;
`endif

endmodule

// File: tb/tb_context_switch_ctrl.sv
// Directed self-checking bench for context_switch_ctrl; PID_W=4 so an out-of-range PID can be driven.
// Runtime counter checks are enabled when CTXSW_RUNTIME_EN is defined.
module tb_context_switch_ctrl;

  localparam int PC_W  = 32;
  localparam int NPROC = 8;
  localparam int PID_W = 4;
  localparam int Q_W   = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             halt;
  logic [PC_W-1:0]  pc_prog_at;
  logic             syscall;
  logic             run_req;
  logic [PID_W-1:0] run_pid;
  logic [Q_W-1:0]   quantum;
  logic             tbl_we;
  logic [PID_W-1:0] tbl_addr;
  logic [PC_W-1:0]  tbl_data;
  logic             prog_or_kernel;
  logic             set_pc_prog;
  logic [PC_W-1:0]  pc_reg;
  logic [PID_W-1:0] cur_pid;
  logic             trap_valid;
  logic [1:0]       trap_cause;
  logic [PID_W-1:0] stat_pid;
  logic [31:0]      stat_cycles;

  int testsRun    = 0;
  int testsFailed = 0;
  int runCnt;

  context_switch_ctrl #(
    .PC_W(PC_W), .NPROC(NPROC), .PID_W(PID_W), .Q_W(Q_W)
  ) dut (
    .clock(clock), .reset(reset), .halt(halt), .pc_prog_at(pc_prog_at),
    .syscall(syscall), .run_req(run_req), .run_pid(run_pid), .quantum(quantum),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .prog_or_kernel(prog_or_kernel), .set_pc_prog(set_pc_prog), .pc_reg(pc_reg),
    .cur_pid(cur_pid), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .stat_pid(stat_pid), .stat_cycles(stat_cycles)
  );

  always #5 clock = ~clock;

  // Advance the given number of clock edges; inputs set before the call are seen by those edges.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Count non-halted RUN cycles until the block leaves program context.
  task automatic countRun(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40 && prog_or_kernel; i++) begin
      cnt++;
      applyStimulus(1);
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; pc_prog_at = '0; syscall = 1'b0; run_req = 1'b0;
    run_pid = '0; quantum = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; stat_pid = '0;
    applyStimulus(2);
    reset = 1'b0;
    checkOutput("rst_prog", 32'(prog_or_kernel), 32'd0);
    checkOutput("rst_set", 32'(set_pc_prog), 32'd0);
    checkOutput("rst_pc", pc_reg, 32'd0);
    checkOutput("rst_pid", 32'(cur_pid), 32'd0);
    checkOutput("rst_trap", 32'(trap_valid), 32'd0);
    checkOutput("rst_cause", 32'(trap_cause), 32'd0);

    // Quantum expiry: table[2]=0x100, 5-cycle slice
    tbl_we = 1'b1; tbl_addr = 4'd2; tbl_data = 32'h100;
    applyStimulus(1);
    tbl_we = 1'b0;
    run_req = 1'b1; run_pid = 4'd2; quantum = 16'd5; pc_prog_at = 32'h1234;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t1_set", 32'(set_pc_prog), 32'd1);
    checkOutput("t1_pc", pc_reg, 32'h100);
    checkOutput("t1_load_prog", 32'(prog_or_kernel), 32'd0);
    checkOutput("t1_pid", 32'(cur_pid), 32'd2);
    applyStimulus(1);
    checkOutput("t1_run_set", 32'(set_pc_prog), 32'd0);
    countRun(runCnt);
    checkOutput("t1_runcnt", 32'(runCnt), 32'd5);
    checkOutput("t1_trap", 32'(trap_valid), 32'd1);
    checkOutput("t1_cause", 32'(trap_cause), 32'd1);
    applyStimulus(1);
    checkOutput("t1_trap_pulse", 32'(trap_valid), 32'd0);
    checkOutput("t1_cause_hold", 32'(trap_cause), 32'd1);

    // Syscall with no preemption: pid 1, quantum 0, syscall on 7th RUN cycle
    run_req = 1'b1; run_pid = 4'd1; quantum = 16'd0;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t2_pc", pc_reg, 32'h0);
    checkOutput("t2_cause_clr", 32'(trap_cause), 32'd0);
    applyStimulus(7);
    checkOutput("t2_still_run", 32'(prog_or_kernel), 32'd1);
    syscall = 1'b1; pc_prog_at = 32'h2A;
    applyStimulus(1);
    syscall = 1'b0;
    checkOutput("t2_prog", 32'(prog_or_kernel), 32'd0);
    checkOutput("t2_trap", 32'(trap_valid), 32'd1);
    checkOutput("t2_cause", 32'(trap_cause), 32'd2);
    applyStimulus(1);
    run_req = 1'b1; run_pid = 4'd1; quantum = 16'd2;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t2_redispatch_pc", pc_reg, 32'h2B);
    checkOutput("t2_redispatch_cause", 32'(trap_cause), 32'd0);
    pc_prog_at = 32'h300;
    applyStimulus(3);
    checkOutput("t2_q2_trap", 32'(trap_valid), 32'd1);
    checkOutput("t2_q2_cause", 32'(trap_cause), 32'd1);
    applyStimulus(1);

    // Syscall coincident with expiry; table[2] must hold 0x1234 from the first save
    run_req = 1'b1; run_pid = 4'd2; quantum = 16'd3;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t3_pc", pc_reg, 32'h1234);
    applyStimulus(3);
    syscall = 1'b1; pc_prog_at = 32'hFFFF_FFFF;
    applyStimulus(1);
    syscall = 1'b0;
    checkOutput("t3_trap", 32'(trap_valid), 32'd1);
    checkOutput("t3_cause", 32'(trap_cause), 32'd2);
    applyStimulus(1);

    // Halt in LOAD, mid-RUN and in SAVE; saved PC wrapped to 0
    run_req = 1'b1; run_pid = 4'd2; quantum = 16'd6;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t4_pc_wrap", pc_reg, 32'h0);
    halt = 1'b1;
    applyStimulus(2);
    checkOutput("t4_set_stretch", 32'(set_pc_prog), 32'd1);
    checkOutput("t4_load_prog", 32'(prog_or_kernel), 32'd0);
    halt = 1'b0;
    applyStimulus(1);
    checkOutput("t4_set_done", 32'(set_pc_prog), 32'd0);
    checkOutput("t4_run", 32'(prog_or_kernel), 32'd1);
    applyStimulus(2);
    halt = 1'b1;
    applyStimulus(4);
    checkOutput("t4_halt_prog", 32'(prog_or_kernel), 32'd1);
    halt = 1'b0; pc_prog_at = 32'h77;
    countRun(runCnt);
    checkOutput("t4_runcnt", 32'(runCnt + 2), 32'd6);
    checkOutput("t4_cause", 32'(trap_cause), 32'd1);
    halt = 1'b1;
    applyStimulus(1);
    checkOutput("t4_trap_stretch", 32'(trap_valid), 32'd1);
    halt = 1'b0;
    applyStimulus(1);
    checkOutput("t4_trap_done", 32'(trap_valid), 32'd0);
`ifdef CTXSW_RUNTIME_EN
    stat_pid = 4'd2;
    #1 checkOutput("t4_stat_pid2", stat_cycles, 32'd14);
    stat_pid = 4'd1;
    #1 checkOutput("t4_stat_pid1", stat_cycles, 32'd9);
`else
    stat_pid = 4'd2;
    #1 checkOutput("t4_stat_off", stat_cycles, 32'd0);
`endif

    // Write-through dispatch, then an out-of-range PID
    tbl_we = 1'b1; tbl_addr = 4'd3; tbl_data = 32'h55;
    run_req = 1'b1; run_pid = 4'd3; quantum = 16'd1;
    applyStimulus(1);
    tbl_we = 1'b0; run_req = 1'b0;
    checkOutput("t5_wt_pc", pc_reg, 32'h55);
    checkOutput("t5_wt_pid", 32'(cur_pid), 32'd3);
    applyStimulus(2);
    checkOutput("t5_q1_trap", 32'(trap_valid), 32'd1);
    applyStimulus(1);
    run_req = 1'b1; run_pid = 4'd9; quantum = 16'd4;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t5_bad_set", 32'(set_pc_prog), 32'd0);
    checkOutput("t5_bad_pid", 32'(cur_pid), 32'd3);
    checkOutput("t5_bad_pc", pc_reg, 32'h55);
    checkOutput("t5_bad_cause", 32'(trap_cause), 32'd1);
    applyStimulus(2);
    checkOutput("t5_bad_prog", 32'(prog_or_kernel), 32'd0);

    // Reset mid-RUN clears outputs, table and counters
    run_req = 1'b1; run_pid = 4'd3; quantum = 16'd0;
    applyStimulus(1);
    run_req = 1'b0;
    checkOutput("t6_pc", pc_reg, 32'h77);
    applyStimulus(2);
    checkOutput("t6_run", 32'(prog_or_kernel), 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("t6_prog", 32'(prog_or_kernel), 32'd0);
    checkOutput("t6_pid", 32'(cur_pid), 32'd0);
    checkOutput("t6_pcreg", pc_reg, 32'd0);
    checkOutput("t6_cause", 32'(trap_cause), 32'd0);
    for (int p = 0; p <= NPROC; p++) begin
      stat_pid = PID_W'(p);
      #1 checkOutput($sformatf("t6_stat%0d", p), stat_cycles, 32'd0);
    end
    pc_prog_at = 32'h0;
    for (int p = 0; p < NPROC; p++) begin
      run_req = 1'b1; run_pid = PID_W'(p); quantum = 16'd1;
      applyStimulus(1);
      run_req = 1'b0;
      checkOutput($sformatf("t6_tbl%0d", p), pc_reg, 32'd0);
      applyStimulus(3);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
